// File: rtl/uart_packet_ctrl_pkg.sv
// Shared types and constants for the UART packet framing controller.
package uart_pkt_pkg;

  // Frame parser states, one per byte position in the frame.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN0,
    ST_LEN1,
    ST_ADDR0,
    ST_ADDR1,
    ST_PAYLOAD,
    ST_CSUM
  } pkt_state_t;

  // Error cause codes reported on err_code_out.
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Default frame start marker.
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_packet_ctrl_if.sv
// Byte input stream and memory-write / status outputs of the packet controller.
interface uart_packet_ctrl_if #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned BYTES_PER_WORD = 2
);

  logic [7:0]                  byte_in;
  logic                        byte_valid_in;
  logic                        wr_en_out;
  logic [ADDR_WIDTH-1:0]       wr_addr_out;
  logic [8*BYTES_PER_WORD-1:0] wr_data_out;
  logic [7:0]                  cmd_out;
  logic                        pkt_done_out;
  logic                        pkt_error_out;
  logic [1:0]                  err_code_out;
  logic                        busy_out;

  // UART receiver / host side: supplies bytes, observes writes and status.
  modport master (
    output byte_in, byte_valid_in,
    input  wr_en_out, wr_addr_out, wr_data_out, cmd_out,
    input  pkt_done_out, pkt_error_out, err_code_out, busy_out
  );

  // Packet controller side.
  modport slave (
    input  byte_in, byte_valid_in,
    output wr_en_out, wr_addr_out, wr_data_out, cmd_out,
    output pkt_done_out, pkt_error_out, err_code_out, busy_out
  );

endinterface

// File: rtl/uart_packet_ctrl_byte_word_packer.sv
// Packs a byte stream little-endian into words; a word is emitted when it
// fills or when the last byte arrives, with unfilled upper bytes zeroed.
module byte_word_packer #(
  parameter int unsigned BYTES_PER_WORD = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [7:0]                  byte_in,
  input  logic                        push_in,
  input  logic                        last_in,
  input  logic                        flush_in,
  output logic [8*BYTES_PER_WORD-1:0] word_out,
  output logic                        word_valid_out
);

  localparam int unsigned W     = 8 * BYTES_PER_WORD;
  localparam int unsigned IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic [IDX_W-1:0] idx;
  logic [W-1:0]     acc;
  logic [W-1:0]     merged;
  logic             word_full;

  // Drop the incoming byte into its lane of the partially built word.
  always_comb begin
    merged = acc;
    for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
      if (idx == IDX_W'(b)) begin
        merged[8*b +: 8] = byte_in;
      end
    end
    word_full = (idx == IDX_W'(BYTES_PER_WORD - 1));
  end

  // Accumulate bytes and emit a registered word with a one-cycle strobe.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      idx            <= '0;
      acc            <= '0;
      word_out       <= '0;
      word_valid_out <= 1'b0;
    end else begin
      word_valid_out <= 1'b0;
      if (flush_in) begin
        idx <= '0;
        acc <= '0;
      end else if (push_in) begin
        if (word_full || last_in) begin
          word_out       <= merged;
          word_valid_out <= 1'b1;
          idx            <= '0;
          acc            <= '0;
        end else begin
          idx <= idx + 1'b1;
          acc <= merged;
        end
      end
    end
  end

endmodule

// File: rtl/uart_packet_ctrl.sv
// Framing controller: hunts for SYNC, parses CMD/LEN/ADDR header, writes
// packed payload words to memory, checks the XOR checksum and aborts
// packets that stall longer than TIMEOUT_CYCLES between bytes.
module uart_packet_ctrl
  import uart_pkt_pkg::*;
#(
  parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES   = 1_000_000,
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned BYTES_PER_WORD   = 2,
  parameter logic [7:0]  SYNC_BYTE        = DEFAULT_SYNC_BYTE
) (
  input  logic              clk_in,
  input  logic              rst_in,
  uart_packet_ctrl_if.slave bus
);

  localparam int unsigned W = 8 * BYTES_PER_WORD;

  // Reject parameter values the datapath cannot support.
  if (BYTES_PER_WORD < 1 || BYTES_PER_WORD > 4 ||
      TIMEOUT_CYCLES == 0 || INPUT_CLOCK_FREQ == 0) begin : g_bad_param
    $error("uart_packet_ctrl: unsupported parameter value");
  end

  pkt_state_t            state;
  logic [7:0]            cmd;
  logic [7:0]            len_lo;
  logic [7:0]            addr_lo;
  logic [15:0]           rem;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            csum;
  logic [31:0]           tcnt;
  logic                  done_pulse;
  logic                  err_pulse;
  logic [1:0]            err_code;

  logic                  timeout_hit;
  logic                  pk_push;
  logic                  pk_last;
  logic [W-1:0]          pk_word;
  logic                  pk_valid;

  // Timeout wins over a byte strobed in the same cycle; that byte is lost.
  always_comb begin
    timeout_hit = (state != ST_IDLE) && (tcnt == 32'(TIMEOUT_CYCLES - 1));
    pk_push     = bus.byte_valid_in && (state == ST_PAYLOAD) && !timeout_hit;
    pk_last     = (rem == 16'd1);
  end

  byte_word_packer #(
    .BYTES_PER_WORD (BYTES_PER_WORD)
  ) u_packer (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .byte_in        (bus.byte_in),
    .push_in        (pk_push),
    .last_in        (pk_last),
    .flush_in       (timeout_hit),
    .word_out       (pk_word),
    .word_valid_out (pk_valid)
  );

  // Frame parser, running checksum, inter-byte timeout and status pulses.
  // The address register is advanced in the cycle its write is presented,
  // so it already points at the next word when that word is emitted.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      cmd        <= '0;
      len_lo     <= '0;
      addr_lo    <= '0;
      rem        <= '0;
      wr_addr    <= '0;
      csum       <= '0;
      tcnt       <= '0;
      done_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err_code   <= '0;
    end else begin
      done_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      if (pk_valid) begin
        wr_addr <= wr_addr + 1'b1;
      end
      if (timeout_hit) begin
        state     <= ST_IDLE;
        tcnt      <= '0;
        err_pulse <= 1'b1;
        err_code  <= ERR_TIMEOUT;
      end else if (bus.byte_valid_in) begin
        tcnt <= '0;
        unique case (state)
          ST_IDLE: begin
            if (bus.byte_in == SYNC_BYTE) begin
              state <= ST_CMD;
            end
          end
          ST_CMD: begin
            cmd   <= bus.byte_in;
            csum  <= bus.byte_in;
            state <= ST_LEN0;
          end
          ST_LEN0: begin
            len_lo <= bus.byte_in;
            csum   <= csum ^ bus.byte_in;
            state  <= ST_LEN1;
          end
          ST_LEN1: begin
            rem   <= {bus.byte_in, len_lo};
            csum  <= csum ^ bus.byte_in;
            state <= ST_ADDR0;
          end
          ST_ADDR0: begin
            addr_lo <= bus.byte_in;
            csum    <= csum ^ bus.byte_in;
            state   <= ST_ADDR1;
          end
          ST_ADDR1: begin
            wr_addr <= ADDR_WIDTH'({bus.byte_in, addr_lo});
            csum    <= csum ^ bus.byte_in;
            state   <= (rem == 16'd0) ? ST_CSUM : ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            csum <= csum ^ bus.byte_in;
            rem  <= rem - 16'd1;
            if (rem == 16'd1) begin
              state <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            state <= ST_IDLE;
            if (bus.byte_in == csum) begin
              done_pulse <= 1'b1;
            end else begin
              err_pulse <= 1'b1;
              err_code  <= ERR_CSUM;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        tcnt <= tcnt + 32'd1;
      end
    end
  end

  // Drive the bus from registered state.
  always_comb begin
    bus.wr_en_out     = pk_valid;
    bus.wr_addr_out   = wr_addr;
    bus.wr_data_out   = pk_word;
    bus.cmd_out       = cmd;
    bus.pkt_done_out  = done_pulse;
    bus.pkt_error_out = err_pulse;
    bus.err_code_out  = err_code;
    bus.busy_out      = (state != ST_IDLE);
  end

endmodule
